// File: rtl/ss_pkg.sv
// Shared types and constants for the 6502 single-step controller.
package ss_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_STOP = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } ss_state_e;

  localparam logic [1:0] MODE_CYC1  = 2'b00;
  localparam logic [1:0] MODE_INST1 = 2'b01;
  localparam logic [1:0] MODE_CYCN  = 2'b10;
  localparam logic [1:0] MODE_INSTN = 2'b11;

  // Instruction modes count SYNC boundaries rather than clocks.
  function automatic logic is_inst_mode(input logic [1:0] m);
    return (m == MODE_INST1) || (m == MODE_INSTN);
  endfunction

endpackage

// File: rtl/ss_step_ctrl_if.sv
// Front-panel / CPU-bus signals of the single-step controller.
interface ss_step_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             ss_en;
  logic             step_btn;
  logic [1:0]       mode;
  logic [CNT_W-1:0] step_count;
  logic             sync;
  logic             rw;
  logic             rdy;
  logic             halted;
  logic             busy;
  logic             wr_hold;
  logic             step_done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output ss_en, step_btn, mode, step_count, sync, rw,
    input  rdy, halted, busy, wr_hold, step_done, remaining
  );

  modport slave (
    input  ss_en, step_btn, mode, step_count, sync, rw,
    output rdy, halted, busy, wr_hold, step_done, remaining
  );
endinterface

// File: rtl/ss_debounce.sv
// Button synchroniser and debouncer; emits a one-clock pulse on each debounced press.
module ss_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic phi2,
  input  logic rst,
  input  logic btn,
  output logic step_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign step_pulse = pulse_q;

endmodule

// File: rtl/ss_step_ctrl.sv
// Single-step controller: drives 6502 RDY for free-run, cycle and instruction stepping.
module ss_step_ctrl
  import ss_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input logic          phi2,
  input logic          rst,
  ss_step_ctrl_if.slave bus
);

  ss_state_e        state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic             done_q, done_d;
  logic             step_pulse;
  logic             inst_mode;
  logic             boundary;
  logic             last_step;

  ss_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .phi2      (phi2),
    .rst       (rst),
    .btn       (bus.step_btn),
    .step_pulse(step_pulse)
  );

  assign inst_mode = is_inst_mode(mode_q);
  assign boundary  = (state_q == ST_STEP) && inst_mode && bus.sync && !first_q;
  assign last_step = (rem_q <= CNT_W'(1));

  always_ff @(posedge phi2) begin
    if (rst) begin
      state_q <= ST_RUN;
      mode_q  <= MODE_CYC1;
      rem_q   <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    first_d = first_q;
    done_d  = 1'b0;
    if (!bus.ss_en) begin
      state_d = ST_RUN;
      rem_d   = '0;
      first_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: state_d = ST_STOP;
        // Only a read cycle can be frozen; writes ignore RDY.
        ST_STOP: begin
          if (bus.rw) begin
            state_d = ST_HALT;
            done_d  = 1'b1;
          end
        end
        ST_HALT: begin
          if (step_pulse) begin
            mode_d  = bus.mode;
            first_d = 1'b1;
            state_d = ST_STEP;
            if (bus.mode == MODE_CYCN || bus.mode == MODE_INSTN) begin
              rem_d = (bus.step_count == '0) ? CNT_W'(1) : bus.step_count;
            end else begin
              rem_d = CNT_W'(1);
            end
          end
        end
        ST_STEP: begin
          first_d = 1'b0;
          if (!inst_mode) begin
            rem_d = last_step ? '0 : rem_q - CNT_W'(1);
            if (last_step) state_d = ST_STOP;
          end else if (boundary) begin
            rem_d = last_step ? '0 : rem_q - CNT_W'(1);
            if (last_step) begin
              state_d = ST_HALT;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    bus.rdy = 1'b1;
    unique case (state_q)
      ST_RUN:  bus.rdy = 1'b1;
      // Terminating SYNC is frozen in the same cycle it appears.
      ST_STEP: bus.rdy = !(boundary && last_step);
      ST_STOP: bus.rdy = !bus.rw;
      ST_HALT: bus.rdy = 1'b0;
      default: bus.rdy = 1'b1;
    endcase
  end

  assign bus.halted    = (state_q == ST_HALT);
  assign bus.busy      = (state_q == ST_STEP) || (state_q == ST_STOP);
  assign bus.wr_hold   = (state_q == ST_STOP) && !bus.rw;
  assign bus.step_done = done_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_ss_step_ctrl.sv
// Scenario bench for ss_step_ctrl with a queue of expected per-cycle outputs.
module tb_ss_step_ctrl;

  typedef struct packed {
    logic       rdy;
    logic       halted;
    logic       busy;
    logic       wr_hold;
    logic       done;
    logic [7:0] rem;
  } obs_t;

  logic phi2 = 1'b0;
  logic rst  = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  obs_t sb[$];

  always #5 phi2 = ~phi2;

  ss_step_ctrl_if #(.CNT_W(8)) bus ();

  ss_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) dut (
    .phi2(phi2),
    .rst (rst),
    .bus (bus)
  );

  function automatic obs_t mk(logic r, logic h, logic b, logic w, logic d, int rem);
    obs_t o;
    o.rdy = r; o.halted = h; o.busy = b; o.wr_hold = w; o.done = d; o.rem = 8'(rem);
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.rdy, bus.halted, bus.busy, bus.wr_hold, bus.step_done, int'(bus.remaining));
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("rdy=%b halted=%b busy=%b wr_hold=%b done=%b rem=%0d",
                     o.rdy, o.halted, o.busy, o.wr_hold, o.done, o.rem);
  endfunction

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  // Starts a step from HALT; returns at the start of the first STEP cycle.
  task automatic press_go(logic [1:0] m, logic [7:0] n);
    bus.step_btn = 1'b0;
    repeat (8) tick();
    bus.mode       = m;
    bus.step_count = n;
    bus.step_btn   = 1'b1;
    repeat (7) tick();
    bus.step_btn = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, g;
    bus.ss_en = 1'b0; bus.step_btn = 1'b0; bus.mode = 2'b00; bus.step_count = 8'd0;
    bus.sync = 1'b0; bus.rw = 1'b1;
    rst = 1'b1;
    tick(); tick();
    sb.push_back(mk(1, 0, 0, 0, 0, 0));
    @(negedge phi2);
    e = sb.pop_front(); g = sample(); n_chk++;
    if (g !== e) begin
      n_fail++; $display("FAIL reset: got %s required %s", fmt(g), fmt(e));
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stop_on_read();
    logic rws[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    obs_t ex[6];
    obs_t e, g;
    ex = '{mk(1, 0, 0, 0, 0, 0), mk(1, 0, 1, 1, 0, 0), mk(1, 0, 1, 1, 0, 0),
           mk(0, 0, 1, 0, 0, 0), mk(0, 1, 0, 0, 1, 0), mk(0, 1, 0, 0, 0, 0)};
    bus.ss_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.rw = rws[k];
      sb.push_back(ex[k]);
      @(negedge phi2);
      e = sb.pop_front(); g = sample(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL stop_on_read cyc %0d: got %s required %s", k, fmt(g), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_single_cycle();
    obs_t e, g;
    bus.mode = 2'b00; bus.rw = 1'b1; bus.sync = 1'b0;
    bus.step_btn = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k == 10) bus.step_btn = 1'b0;
      // Pulse lands 6 clocks after the press; STEP follows on the next clock.
      if (k == 7)      sb.push_back(mk(1, 0, 1, 0, 0, 1));
      else if (k == 8) sb.push_back(mk(0, 0, 1, 0, 0, 0));
      else if (k == 9) sb.push_back(mk(0, 1, 0, 0, 1, 0));
      else             sb.push_back(mk(0, 1, 0, 0, 0, 0));
      @(negedge phi2);
      e = sb.pop_front(); g = sample(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL single_cycle cyc %0d: got %s required %s", k, fmt(g), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_glitch();
    obs_t e, g;
    repeat (8) tick();
    for (int k = 0; k < 12; k++) begin
      bus.step_btn = (k < 2);
      sb.push_back(mk(0, 1, 0, 0, 0, 0));
      @(negedge phi2);
      e = sb.pop_front(); g = sample(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL glitch cyc %0d: got %s required %s", k, fmt(g), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_n_cycles();
    obs_t e, g;
    bus.rw = 1'b1;
    press_go(2'b10, 8'd5);
    for (int j = 0; j < 7; j++) begin
      if (j < 5)       sb.push_back(mk(1, 0, 1, 0, 0, 5 - j));
      else if (j == 5) sb.push_back(mk(0, 0, 1, 0, 0, 0));
      else             sb.push_back(mk(0, 1, 0, 0, 1, 0));
      @(negedge phi2);
      e = sb.pop_front(); g = sample(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL n_cycles cyc %0d: got %s required %s", j, fmt(g), fmt(e));
      end
      tick();
    end
    press_go(2'b10, 8'd0);
    for (int j = 0; j < 3; j++) begin
      if (j == 0)      sb.push_back(mk(1, 0, 1, 0, 0, 1));
      else if (j == 1) sb.push_back(mk(0, 0, 1, 0, 0, 0));
      else             sb.push_back(mk(0, 1, 0, 0, 1, 0));
      @(negedge phi2);
      e = sb.pop_front(); g = sample(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL count_zero cyc %0d: got %s required %s", j, fmt(g), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_n_inst();
    logic syncs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    obs_t e, g;
    bus.rw = 1'b1;
    press_go(2'b11, 8'd2);
    for (int j = 0; j < 7; j++) begin
      bus.sync = syncs[j];
      if (j <= 3)      sb.push_back(mk(1, 0, 1, 0, 0, 2));
      else if (j == 4) sb.push_back(mk(1, 0, 1, 0, 0, 1));
      else if (j == 5) sb.push_back(mk(0, 0, 1, 0, 0, 1));
      else             sb.push_back(mk(0, 1, 0, 0, 1, 0));
      @(negedge phi2);
      e = sb.pop_front(); g = sample(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL n_inst cyc %0d: got %s required %s", j, fmt(g), fmt(e));
      end
      tick();
    end
    bus.sync = 1'b0;
  endtask

  task automatic test_press_during_step();
    obs_t e, g;
    bus.rw = 1'b1;
    press_go(2'b10, 8'd20);
    for (int j = 0; j < 26; j++) begin
      bus.step_btn = (j >= 7 && j < 15);
      if (j < 20)       sb.push_back(mk(1, 0, 1, 0, 0, 20 - j));
      else if (j == 20) sb.push_back(mk(0, 0, 1, 0, 0, 0));
      else if (j == 21) sb.push_back(mk(0, 1, 0, 0, 1, 0));
      else              sb.push_back(mk(0, 1, 0, 0, 0, 0));
      @(negedge phi2);
      e = sb.pop_front(); g = sample(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL press_in_step cyc %0d: got %s required %s", j, fmt(g), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_ss_drop();
    logic syncs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    obs_t e, g;
    bus.rw = 1'b1;
    press_go(2'b11, 8'd3);
    for (int j = 0; j < 6; j++) begin
      bus.sync  = syncs[j];
      bus.ss_en = (j < 2);
      bus.rw    = j[0];
      if (j < 3) sb.push_back(mk(1, 0, 1, 0, 0, 3));
      else       sb.push_back(mk(1, 0, 0, 0, 0, 0));
      @(negedge phi2);
      e = sb.pop_front(); g = sample(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL ss_drop cyc %0d: got %s required %s", j, fmt(g), fmt(e));
      end
      tick();
    end
    bus.sync = 1'b0; bus.rw = 1'b1; bus.ss_en = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_rst_mid_step();
    obs_t e, g;
    bus.rw = 1'b1;
    press_go(2'b10, 8'd5);
    for (int j = 0; j < 4; j++) begin
      rst = (j == 1 || j == 2);
      if (j == 0)      sb.push_back(mk(1, 0, 1, 0, 0, 5));
      else if (j == 1) sb.push_back(mk(1, 0, 1, 0, 0, 4));
      else             sb.push_back(mk(1, 0, 0, 0, 0, 0));
      @(negedge phi2);
      e = sb.pop_front(); g = sample(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL rst_mid_step cyc %0d: got %s required %s", j, fmt(g), fmt(e));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stop_on_read();
    test_single_cycle();
    test_glitch();
    test_n_cycles();
    test_n_inst();
    test_press_during_step();
    test_ss_drop();
    test_rst_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ss_step_ctrl.md
Name: ss_step_ctrl

Overview:
- Parametrised, single-clock successor to the 6502 single-step controller. It sits between the front-panel STEP button, the CPU bus status (SYNC, R/W) and the CPU RDY pin.
- Supports free-run, single-cycle, single-instruction, N-cycle and N-instruction stepping.
- Debounces the raw button internally.
- Never stops the CPU on a write cycle, because the NMOS 6502 ignores RDY on writes.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive phi2 clocks the button must be stable before its debounced level changes.
- CNT_W, 8, width of the step counter and the step_count input.

Ports:
- phi2  in  1  system clock, rising edge, one CPU cycle per clock.
- rst  in  1  synchronous reset, active-high.
- ss_en  in  1  1 = single-step mode; 0 = free run.
- step_btn  in  1  raw step button, active high, asynchronous to phi2 (double-registered inside).
- mode  in  2  00 = 1 cycle; 01 = 1 instruction; 10 = N cycles; 11 = N instructions.
- step_count  in  CNT_W  N for modes 10/11. A value of 0 is treated as 1.
- sync  in  1  6502 SYNC (opcode fetch).
- rw  in  1  6502 R/W (1 = read).
- rdy  out  1  6502 RDY (1 = CPU runs).
- halted  out  1  state == HALT.
- busy  out  1  state is STEP or STOP.
- wr_hold  out  1  STOP && !rw: halt is being deferred past a write.
- step_done  out  1  one-clock pulse on entry to HALT.
- remaining  out  CNT_W  steps left in the current STEP burst.

Behaviour:
- Reset values: state RUN, rdy=1, halted=0, busy=0, wr_hold=0, step_done=0, remaining=0. Debouncer level and counter are cleared to 0. Reset applied mid-step aborts the step immediately.
- Debounce:
  - The synchronised button must differ from the debounced level for DEBOUNCE_CYCLES consecutive clocks before the level flips.
  - step_pulse is a one-clock pulse on each 0->1 transition of the debounced level.
  - Latency from a clean button press to step_pulse is 2 + DEBOUNCE_CYCLES clocks.
- States: RUN, STOP, HALT, STEP.
- rdy decode (combinational):
  - RUN: 1.
  - STEP: 1, except in instruction modes with the terminating sync cycle (see STEP), where it is 0.
  - STOP: !rw.
  - HALT: 0.
- RUN: if ss_en, go to STOP.
- STOP: the CPU runs until the first read cycle.
  - rw=1 -> HALT (rdy already 0 in that cycle); pulse step_done.
  - rw=0 -> stay in STOP.
  - If !ss_en -> RUN (takes priority).
- HALT:
  - If !ss_en -> RUN.
  - Else on step_pulse:
    - Latch the mode.
    - Load remaining with 1 for modes 00/01, or max(step_count,1) for modes 10/11.
    - Set first=1 and go to STEP.
  - step_pulse while !ss_en is ignored.
- STEP, cycle modes:
  - remaining decrements every clock.
  - At the clock where remaining==1, go to STOP.
  - rdy is therefore high for exactly N clocks, then the controller halts on the next read cycle.
- STEP, instruction modes:
  - first clears after the first STEP clock.
  - A sync with first=0 marks an instruction boundary.
  - If remaining==1 at a boundary: rdy=0 combinationally in that cycle, go to HALT and pulse step_done. The CPU is held on the next opcode fetch; sync is always a read.
  - Otherwise remaining decrements at the boundary.
- STEP, control:
  - step_pulse is ignored in STEP (no queuing). mode and step_count changes take effect only at the next step start.
  - !ss_en in any state -> RUN next clock, with remaining cleared.
- Width rules:
  - remaining never decrements below 0.
  - A step_count of all-ones yields 2^CNT_W-1 steps; there is no wrap.

Decomposition:
- Shared package ss_pkg:
  - state encoding constants ST_RUN, ST_STOP, ST_HALT, ST_STEP;
  - mode constants MODE_CYC1, MODE_INST1, MODE_CYCN, MODE_INSTN.
- One sub-module: ss_debounce (synchroniser, stability counter, level and rising-edge pulse; parameter DEBOUNCE_CYCLES).

Test Plan:
- Reset, then ss_en=1 with rw toggling 0,0,1 -> rdy stays 1 and wr_hold=1 through the two write cycles. rdy=0 in the read cycle, then halted=1 and step_done pulses once.
- HALT, mode=00, button held 10 clocks with DEBOUNCE_CYCLES=4 -> step_pulse 6 clocks after the press. rdy=1 for exactly 1 clock, then HALT on the next read.
- HALT, mode=10, step_count=5, all reads -> rdy high for 5 clocks, then 0 in the 6th; remaining steps 5,4,3,2,1,0.
- HALT, mode=11, step_count=2, sync pattern 1,0,0,1,0,1 -> rdy=0 in the third sync cycle and HALT. step_count=0 with mode=10 -> behaves as 1 cycle.
- A 2-clock button glitch (shorter than DEBOUNCE_CYCLES) -> no step_pulse. A second press during STEP -> ignored, no extra steps.
- ss_en dropped mid-STEP (mode=11, N=3) -> RUN next clock, rdy=1 continuously. rst asserted mid-STEP -> all outputs take their reset values on the next clock.
